xadc_avg_filter: RTL

Four-channel moving-average (boxcar) filter that sits directly downstream of the XADC DRP read logic and upstream of the LED PWM duty registers. It accepts one tagged 12-bit XADC conversion result per valid cycle and keeps an independent window of the last 2^LOG2_LEN samples per channel. It emits the channel's window mean one cycle later, so the PWM stage sees smoothed brightness instead of raw conversion noise.

---
 rtl/xadc_avg_filter.sv | 73 +++++++
 1 files changed

// File: rtl/xadc_avg_filter.sv
// Four-channel boxcar filter for tagged XADC samples; each channel keeps its
// own ring of the last 2^LOG2_LEN samples and a running sum of that window.
module xadc_avg_filter #(
  parameter int DATA_W   = 12,
  parameter int LOG2_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [1:0]        out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed
);

  // Handshake: no ready. A sample is accepted on every rising edge where
  // in_valid is high and rst is low; its result appears with out_valid high
  // exactly one edge later. out_valid is never high without a matching sample.

  localparam int LEN   = 1 << LOG2_LEN;
  localparam int SUM_W = DATA_W + LOG2_LEN;
  localparam int N_CH  = 4;

  logic [DATA_W-1:0]   tap_mem [N_CH][LEN];
  logic [LOG2_LEN-1:0] ptr     [N_CH];
  logic [SUM_W-1:0]    sum     [N_CH];
  logic                primed  [N_CH];

  logic [LOG2_LEN-1:0] cur_ptr;
  logic [DATA_W-1:0]   old_sample;
  logic [SUM_W-1:0]    new_sum;
  logic                last_tap;

  // Current-cycle read of the selected channel; a same-channel sample on the
  // next cycle sees the registered update, so back-to-back needs no bypass.
  always_comb begin
    cur_ptr    = ptr[in_ch];
    old_sample = tap_mem[in_ch][cur_ptr];
    new_sum    = sum[in_ch] + SUM_W'(in_data) - SUM_W'(old_sample);
    last_tap   = (cur_ptr == LOG2_LEN'(LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int t = 0; t < LEN; t++) begin
          tap_mem[c][t] <= '0;
        end
        ptr[c]    <= '0;
        sum[c]    <= '0;
        primed[c] <= 1'b0;
      end
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        tap_mem[in_ch][cur_ptr] <= in_data;
        sum[in_ch]              <= new_sum;
        ptr[in_ch]              <= cur_ptr + LOG2_LEN'(1);
        primed[in_ch]           <= primed[in_ch] | last_tap;
        out_data                <= new_sum[SUM_W-1:LOG2_LEN];
        out_ch                  <= in_ch;
        out_primed              <= primed[in_ch] | last_tap;
      end
    end
  end

endmodule
